mmio_io_ctrl: RTL and testbench
===============================

// Module: mmio_io_ctrl
// PURPOSE
//  Parametrised memory-mapped IO controller. It replaces the fixed
//  switch-read, LED-write, dual scan4 and per-button debounce glue with one
//  register-mapped block. It sits between MemOrIO (IORead/IOWrite decode) and
//  the board pins, and serves switches, LEDs, an N-digit 7-seg display and N
//  debounced buttons with sticky event flags.
// PARAMETERS
//  SW_W       24      switch input width (<=32)
//  LED_W      24      LED output width (<=32)
//  N_DIGITS   8       7-seg digits scanned, 1..8; 4 bits/digit in SEG_DATA
//  N_BTN      5       debounced push buttons (<=32)
//  DB_CYCLES  20000   cycles a raw button must be stable before acceptance
//  SCAN_DIV   50000   cycles each digit is enabled
//  SEG_ACT_LO 0       1 = seg_en/seg_out active-low, 0 = active-high
// PORTS
//  clock     in   1         system clock (clk1 domain)
//  rst_n     in   1         asynchronous active-low reset
//  io_rd     in   1         read strobe from MemOrIO
//  io_wr     in   1         write strobe from MemOrIO
//  io_addr   in   5         byte offset inside block window; [1:0] ignored
//  io_wdata  in   32        write data
//  io_rdata  out  32        read data, combinational from registers
//  switches  in   SW_W      raw switch pins (asynchronous)
//  buttons   in   N_BTN     raw button pins (asynchronous, active-high)
//  leds      out  LED_W     LED pins
//  seg_en    out  N_DIGITS  digit enables
//  seg_out   out  8         segments {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  Register map (word offsets):
//   0x00 SW  RO : 2-flop-synchronised switches, zero-extended
//   0x04 LED RW : LED_W bits
//   0x08 SEG RW : digit k = bits[4k+3:4k], shown as hex 0-F
//   0x0C BLK RW : [N_DIGITS-1:0] blank mask (1 = digit dark); [8] dp on all
//   0x10 EVT W1C: bit i set on debounced rising edge of button i
//   0x14 LVL RO : debounced button levels
//   other offsets: reads return 0, writes are ignored
//  - Reset (async, rst_n=0): LED, SEG, BLK, EVT, LVL, synchronisers,
//    debounce counters, scan counter and digit index all clear to 0.
//    leds=0; seg_en and seg_out are at their inactive level.
//  - io_rdata = 0 when io_rd=0. When io_rd=1, the value tracks the current
//    register contents in the same cycle. No read side effects.
//  - Writes commit on the rising clock edge when io_wr=1. The new value is
//    visible on reads in the following cycle. io_rd and io_wr both high is
//    legal; the read returns the old value.
//  - Debounce, per button: state {STABLE, COUNTING}.
//    * A synchronised raw value different from the debounced level moves the
//      button to COUNTING with cnt=0.
//    * The raw value reverting before cnt reaches DB_CYCLES-1 returns the
//      button to STABLE with no change.
//    * Reaching DB_CYCLES-1 updates the level. On a 0->1 change, EVT[i] is
//      set in that cycle.
//  - EVT: writing 1 clears the bit; writing 0 leaves it. A set and a clear
//    in the same cycle leave the bit SET, so no event is lost.
//  - Scan: prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances
//    and wraps from N_DIGITS-1 to 0. Exactly one digit is enabled at a time
//    unless it is blanked, in which case all digits are off.
//    seg_out is the hex decode of the current digit plus the dp flag.
//    Outputs are registered, so the digit enable and its segments change in
//    the same cycle with no ghosting.
//  - An SEG write takes effect on the next displayed digit and does not
//    reset the scan.
// STRUCTURE
//  - Shared header (definitions.v): register offsets `IO_SW..`IO_LVL and
//    the hex-to-7-seg table as a function or `define.
//  - Sub-module btn_debounce (params DB_CYCLES; ports clock, rst_n, raw,
//    level, rise), instantiated N_BTN times in a generate loop.
//  - The register file, read mux and scanner stay inline.
// TESTING (bench: DB_CYCLES=4, SCAN_DIV=3, N_DIGITS=8)
//  1 Reset: rst_n=0 mid-scan -> leds=0, seg_en inactive, all reads 0.
//    After release, the first digit-0 enable appears 3 cycles later.
//  2 Write 0x04=0x00A5A5A5 -> leds=0xA5A5A5 next cycle.
//    Set switches=0x123456 -> 0x00 reads 0x00123456 after 2 cycles.
//  3 Write 0x08=0x76543210, 0x0C=0x00000004 -> digits 0..7 show 0..7 in
//    turn, 3 cycles each, and digit 2 stays dark.
//  4 Button 1 pulses high for 2 cycles -> no EVT.
//    Held high 10 cycles -> EVT=0x2 and LVL=0x2 after 2+4 cycles.
//    Release -> LVL=0 and EVT stays 0x2.
//  5 Write 0x10=0x2 in the same cycle as a new button-1 rise -> EVT[1]=1.
//    Write 0x10=0x2 on a later idle cycle -> EVT=0.
//  6 Write to 0x1C -> no register changes; read of 0x1C returns 0.

Source files
------------

// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the MMIO IO controller: register offsets,
// debounce FSM states and the hex-to-7-segment table.
package mmio_io_ctrl_pkg;

  localparam logic [4:0] IO_SW  = 5'h00;
  localparam logic [4:0] IO_LED = 5'h04;
  localparam logic [4:0] IO_SEG = 5'h08;
  localparam logic [4:0] IO_BLK = 5'h0C;
  localparam logic [4:0] IO_EVT = 5'h10;
  localparam logic [4:0] IO_LVL = 5'h14;

  localparam int unsigned BLK_DP_BIT = 8;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

  // Active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_btn_debounce.sv
// Single-button synchroniser and debouncer; level follows raw once it has
// been stable for DB_CYCLES cycles, rise pulses on an accepted 0->1 change.
module btn_debounce
  import mmio_io_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned LAST = (DB_CYCLES > 1) ? DB_CYCLES - 2 : 0;

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  db_state_e     r_state;

  db_state_e     w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_level_nx;
  logic          w_rise;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_state <= DB_STABLE;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_level <= w_level_nx;
      r_cnt   <= w_cnt_nx;
      r_state <= w_state_nx;
    end
  end

  // The level commits on the edge where the counter would reach DB_CYCLES-1,
  // so acceptance takes DB_CYCLES edges after the synchroniser.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_level_nx = r_level;
    w_rise     = 1'b0;
    case (r_state)
      DB_STABLE: begin
        if (r_s2 != r_level) begin
          w_state_nx = DB_COUNTING;
          w_cnt_nx   = '0;
        end
      end
      DB_COUNTING: begin
        if (r_s2 == r_level) begin
          w_state_nx = DB_STABLE;
        end else if (r_cnt >= CW'(LAST)) begin
          w_level_nx = r_s2;
          w_rise     = r_s2;
          w_state_nx = DB_STABLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = DB_STABLE;
    endcase
  end

  assign level = r_level;
  assign rise  = w_rise;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped IO controller: switches, LEDs, scanned 7-seg display and
// debounced buttons with sticky write-1-to-clear event flags.
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int unsigned SW_W       = 24,
  parameter int unsigned LED_W      = 24,
  parameter int unsigned N_DIGITS   = 8,
  parameter int unsigned N_BTN      = 5,
  parameter int unsigned DB_CYCLES  = 20000,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          SEG_ACT_LO = 1'b0
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                io_rd,
  input  logic                io_wr,
  input  logic [4:0]          io_addr,
  input  logic [31:0]         io_wdata,
  output logic [31:0]         io_rdata,
  input  logic [SW_W-1:0]     switches,
  input  logic [N_BTN-1:0]    buttons,
  output logic [LED_W-1:0]    leds,
  output logic [N_DIGITS-1:0] seg_en,
  output logic [7:0]          seg_out
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] EN_OFF  = SEG_ACT_LO ? '1 : '0;
  localparam logic [7:0]          OUT_OFF = SEG_ACT_LO ? '1 : '0;

  logic [SW_W-1:0]       r_sw_s1;
  logic [SW_W-1:0]       r_sw_s2;
  logic [LED_W-1:0]      r_led;
  logic [4*N_DIGITS-1:0] r_seg;
  logic [N_DIGITS-1:0]   r_blank;
  logic                  r_dp;
  logic [N_BTN-1:0]      r_evt;
  logic [PW-1:0]         r_pre;
  logic [DW-1:0]         r_digit;
  logic [N_DIGITS-1:0]   r_seg_en;
  logic [7:0]            r_seg_out;

  logic [4:0]            w_word;
  logic [N_BTN-1:0]      w_lvl;
  logic [N_BTN-1:0]      w_rise;
  logic [N_BTN-1:0]      w_evt_clr;
  logic [31:0]           w_rdata;
  logic                  w_wrap;
  logic [3:0]            w_nib;
  logic                  w_on;
  logic [N_DIGITS-1:0]   w_en_act;
  logic [7:0]            w_out_act;
  logic                  w_unused;

  assign w_word   = {io_addr[4:2], 2'b00};
  assign w_unused = &{1'b0, io_addr[1:0], io_wdata};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clock(clock),
      .rst_n(rst_n),
      .raw  (buttons[g]),
      .level(w_lvl[g]),
      .rise (w_rise[g])
    );
  end

  assign w_evt_clr = (io_wr && (w_word == IO_EVT)) ? io_wdata[N_BTN-1:0] : '0;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_led   <= '0;
      r_seg   <= '0;
      r_blank <= '0;
      r_dp    <= 1'b0;
      r_evt   <= '0;
    end else begin
      r_sw_s1 <= switches;
      r_sw_s2 <= r_sw_s1;
      if (io_wr && (w_word == IO_LED)) r_led <= io_wdata[LED_W-1:0];
      if (io_wr && (w_word == IO_SEG)) r_seg <= io_wdata[4*N_DIGITS-1:0];
      if (io_wr && (w_word == IO_BLK)) begin
        r_blank <= io_wdata[N_DIGITS-1:0];
        r_dp    <= io_wdata[BLK_DP_BIT];
      end
      // Set dominates clear so an event arriving during a clear is kept.
      r_evt <= (r_evt & ~w_evt_clr) | w_rise;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (io_rd) begin
      case (w_word)
        IO_SW:  w_rdata[SW_W-1:0]       = r_sw_s2;
        IO_LED: w_rdata[LED_W-1:0]      = r_led;
        IO_SEG: w_rdata[4*N_DIGITS-1:0] = r_seg;
        IO_BLK: begin
          w_rdata[N_DIGITS-1:0] = r_blank;
          w_rdata[BLK_DP_BIT]   = r_dp;
        end
        IO_EVT: w_rdata[N_BTN-1:0]      = r_evt;
        IO_LVL: w_rdata[N_BTN-1:0]      = w_lvl;
        default: w_rdata = '0;
      endcase
    end
  end

  assign io_rdata = w_rdata;
  assign leds     = r_led;

  assign w_wrap = (r_pre == PW'(SCAN_DIV - 1));

  always_comb begin
    w_nib    = r_seg[4*r_digit +: 4];
    w_on     = ~r_blank[r_digit];
    w_en_act = '0;
    if (w_on) w_en_act[r_digit] = 1'b1;
    w_out_act = w_on ? {r_dp, hex7(w_nib)} : 8'h00;
  end

  // Enable and segments load together at each wrap from the digit being
  // left, so the first digit appears SCAN_DIV cycles after reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_digit   <= '0;
      r_seg_en  <= EN_OFF;
      r_seg_out <= OUT_OFF;
    end else if (w_wrap) begin
      r_pre     <= '0;
      r_digit   <= (r_digit == DW'(N_DIGITS - 1)) ? '0 : r_digit + 1'b1;
      r_seg_en  <= SEG_ACT_LO ? ~w_en_act : w_en_act;
      r_seg_out <= SEG_ACT_LO ? ~w_out_act : w_out_act;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign seg_en  = r_seg_en;
  assign seg_out = r_seg_out;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl with short debounce and scan periods.
module tb_mmio_io_ctrl;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        io_rd;
  logic        io_wr;
  logic [4:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [23:0] switches;
  logic [4:0]  buttons;
  logic [23:0] leds;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] seg_tbl [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};

  mmio_io_ctrl #(
    .SW_W(24), .LED_W(24), .N_DIGITS(8), .N_BTN(5),
    .DB_CYCLES(4), .SCAN_DIV(3), .SEG_ACT_LO(1'b0)
  ) dut (
    .clock(clock), .rst_n(rst_n), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .switches(switches), .buttons(buttons), .leds(leds),
    .seg_en(seg_en), .seg_out(seg_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    io_wr = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_wr = 1'b0; io_wdata = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    io_rd = 1'b1; io_addr = a;
    #1;
    d = io_rdata;
    io_rd = 1'b0;
  endtask

  task automatic wait_en(input logic [7:0] en, input int unsigned max, output logic ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < max && !ok; i++) begin
      tick();
      if (seg_en == en) ok = 1'b1;
    end
  endtask

  task automatic sync_digit0(input string tag);
    logic ok;
    wait_en(8'h80, 40, ok);
    chk({tag, "_wait_d7"}, {31'd0, ok}, 32'd1);
    wait_en(8'h01, 10, ok);
    chk({tag, "_wait_d0"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_wdata = '0;
    switches = '0; buttons = '0;
    tick(2);
    rst_n = 1'b1;

    // 1: reset in the middle of a scan
    bus_write(5'h04, 32'h0000_0055);
    bus_write(5'h08, 32'h1234_5678);
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("rst_leds", {8'd0, leds}, 32'd0);
    chk("rst_seg_en", {24'd0, seg_en}, 32'd0);
    chk("rst_seg_out", {24'd0, seg_out}, 32'd0);
    bus_read(5'h04, rd); chk("rst_rd_led", rd, 32'd0);
    bus_read(5'h08, rd); chk("rst_rd_seg", rd, 32'd0);
    bus_read(5'h10, rd); chk("rst_rd_evt", rd, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(2);
    chk("rst_en_2cyc", {24'd0, seg_en}, 32'd0);
    tick();
    chk("rst_en_3cyc", {24'd0, seg_en}, 32'h01);
    chk("rst_out_3cyc", {24'd0, seg_out}, 32'h3F);

    // 2: LED write, switch synchroniser, read-idle, read+write together
    bus_write(5'h04, 32'h00A5_A5A5);
    chk("led_pins", {8'd0, leds}, 32'h00A5_A5A5);
    bus_read(5'h04, rd); chk("led_rd", rd, 32'h00A5_A5A5);
    io_addr = 5'h04; #1;
    chk("rd_idle_zero", io_rdata, 32'd0);
    switches = 24'h123456;
    tick();
    bus_read(5'h00, rd); chk("sw_1cyc", rd, 32'd0);
    tick();
    bus_read(5'h00, rd); chk("sw_2cyc", rd, 32'h0012_3456);
    io_rd = 1'b1; io_wr = 1'b1; io_addr = 5'h04; io_wdata = 32'h000F_0F0F;
    #1;
    chk("rw_old", io_rdata, 32'h00A5_A5A5);
    tick();
    io_rd = 1'b0; io_wr = 1'b0;
    chk("rw_new", {8'd0, leds}, 32'h000F_0F0F);

    // 3: scan through all digits with digit 2 blanked
    bus_write(5'h08, 32'h7654_3210);
    bus_write(5'h0C, 32'h0000_0004);
    sync_digit0("scan");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scan_en_d%0d", k), {24'd0, seg_en}, (k == 2) ? 32'd0 : (32'd1 << k));
      chk($sformatf("scan_out_d%0d", k), {24'd0, seg_out}, (k == 2) ? 32'd0 : {24'd0, seg_tbl[k]});
      tick(3);
    end
    bus_write(5'h0C, 32'h0000_0100);
    sync_digit0("dp");
    chk("dp_out_d0", {24'd0, seg_out}, 32'hBF);

    // 4: debounce
    buttons = 5'b00010;
    tick(2);
    buttons = '0;
    tick(10);
    bus_read(5'h10, rd); chk("glitch_evt", rd, 32'd0);
    bus_read(5'h14, rd); chk("glitch_lvl", rd, 32'd0);
    buttons = 5'b00010;
    tick(5);
    bus_read(5'h14, rd); chk("press_lvl_5", rd, 32'd0);
    tick();
    bus_read(5'h14, rd); chk("press_lvl_6", rd, 32'h2);
    bus_read(5'h10, rd); chk("press_evt_6", rd, 32'h2);
    tick(4);
    buttons = '0;
    tick(10);
    bus_read(5'h14, rd); chk("release_lvl", rd, 32'd0);
    bus_read(5'h10, rd); chk("release_evt", rd, 32'h2);

    // 5: W1C behaviour and set-over-clear
    bus_write(5'h10, 32'h0);
    bus_read(5'h10, rd); chk("evt_w0_keep", rd, 32'h2);
    bus_write(5'h10, 32'h2);
    bus_read(5'h10, rd); chk("evt_clr", rd, 32'd0);
    buttons = 5'b00010;
    tick(5);
    bus_write(5'h10, 32'h2);
    bus_read(5'h10, rd); chk("evt_set_wins", rd, 32'h2);
    buttons = '0;
    tick(10);
    bus_write(5'h10, 32'h2);
    bus_read(5'h10, rd); chk("evt_clr_idle", rd, 32'd0);

    // 6: unmapped offset
    bus_write(5'h1C, 32'hFFFF_FFFF);
    bus_read(5'h04, rd); chk("unmap_led", rd, 32'h000F_0F0F);
    bus_read(5'h08, rd); chk("unmap_seg", rd, 32'h7654_3210);
    bus_read(5'h0C, rd); chk("unmap_blk", rd, 32'h0000_0100);
    bus_read(5'h10, rd); chk("unmap_evt", rd, 32'd0);
    bus_read(5'h1C, rd); chk("unmap_rd", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
